wb_regfile_retire: RTL and testbench

- Consumer end of the M->W writeback bundle in the pipelined ARM core.
- Selects the writeback result and commits it to architectural registers R0-R14.
- Serves both decode-stage read ports, with R15 reading as PC+8.
- Drives the PC redirect for writes to R15, keeps a retired-instruction counter, and sets a sticky error flag on illegal R15 writes.

---
 rtl/wb_pkg.sv | 12 +
 rtl/regfile_core.sv | 34 +++
 rtl/wb_regfile_retire.sv | 106 ++++++++++
 tb/tb_wb_regfile_retire.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback/register-file retire block.
package wb_pkg;

  localparam int unsigned DATA_W        = 32;
  localparam int unsigned NUM_ARCH_REGS = 15;

  typedef logic [3:0]        reg_idx_t;
  typedef logic [DATA_W-1:0] word_t;

  localparam reg_idx_t REG_PC = 4'd15;

endpackage

// File: rtl/regfile_core.sv
// Architectural register storage R0-R14: one write port, two raw read ports.
// Reads of an index outside the array return zero; the top maps R15 itself.
module regfile_core
  import wb_pkg::NUM_ARCH_REGS;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              we_i,
  input  logic [3:0]        waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [3:0]        raddr1_i,
  input  logic [3:0]        raddr2_i,
  output logic [DATA_W-1:0] rdata1_o,
  output logic [DATA_W-1:0] rdata2_o
);

  logic [DATA_W-1:0] mem_q [NUM_ARCH_REGS];

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < int'(NUM_ARCH_REGS); i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i && (32'(waddr_i) < NUM_ARCH_REGS)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata1_o = (32'(raddr1_i) < NUM_ARCH_REGS) ? mem_q[raddr1_i] : '0;
  assign rdata2_o = (32'(raddr2_i) < NUM_ARCH_REGS) ? mem_q[raddr2_i] : '0;

endmodule

// File: rtl/wb_regfile_retire.sv
// W-stage consumer: result select, register commit, decode read ports, PC redirect,
// retire counter and sticky illegal-R15-write flag. Define WB_BYPASS_EN for W->D bypass.
module wb_regfile_retire
  import wb_pkg::REG_PC;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              PCSrcW,
  input  logic              RegWriteW,
  input  logic              MemtoRegW,
  input  logic [3:0]        RdW,
  input  logic [DATA_W-1:0] ALUResultW,
  input  logic [DATA_W-1:0] ReadDataW,
  input  logic [3:0]        RA1D,
  input  logic [3:0]        RA2D,
  input  logic [DATA_W-1:0] PCPlus8D,
  output logic [DATA_W-1:0] RD1D,
  output logic [DATA_W-1:0] RD2D,
  output logic [DATA_W-1:0] ResultW,
  output logic              PCRedirectW,
  output logic [DATA_W-1:0] PCTargetW,
  output logic [CNT_W-1:0]  RetireCount,
  output logic              IllegalWrErr
);

  logic              arr_we_c;
  logic [DATA_W-1:0] raw1_c;
  logic [DATA_W-1:0] raw2_c;
  logic              hit1_c;
  logic              hit2_c;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;

  assign ResultW     = MemtoRegW ? ReadDataW : ALUResultW;
  assign PCRedirectW = PCSrcW;
  assign PCTargetW   = ResultW;

  // R15 is never stored; a PC write only redirects fetch.
  assign arr_we_c = RegWriteW && (RdW != REG_PC);

  regfile_core #(
    .DATA_W (DATA_W)
  ) u_core (
    .clk_i    (clk),
    .rst_n_i  (reset),
    .we_i     (arr_we_c),
    .waddr_i  (RdW),
    .wdata_i  (ResultW),
    .raddr1_i (RA1D),
    .raddr2_i (RA2D),
    .rdata1_o (raw1_c),
    .rdata2_o (raw2_c)
  );

`ifdef WB_BYPASS_EN
  assign hit1_c = RegWriteW && (RdW == RA1D);
  assign hit2_c = RegWriteW && (RdW == RA2D);
`else
  assign hit1_c = 1'b0;
  assign hit2_c = 1'b0;
`endif

  // R15 mapping wins over bypass, bypass wins over stored value.
  always_comb begin
    RD1D = raw1_c;
    RD2D = raw2_c;
    if (RA1D == REG_PC) begin
      RD1D = PCPlus8D;
    end else if (hit1_c) begin
      RD1D = ResultW;
    end
    if (RA2D == REG_PC) begin
      RD2D = PCPlus8D;
    end else if (hit2_c) begin
      RD2D = ResultW;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (RegWriteW || PCSrcW) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    if (RegWriteW && (RdW == REG_PC) && !PCSrcW) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign RetireCount  = cnt_q;
  assign IllegalWrErr = err_q;

endmodule

// File: tb/tb_wb_regfile_retire.sv
// Self-checking bench for wb_regfile_retire (CNT_W=4) against a behavioural model.
module tb_wb_regfile_retire;

  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             PCSrcW, RegWriteW, MemtoRegW;
  logic [3:0]       RdW, RA1D, RA2D;
  logic [31:0]      ALUResultW, ReadDataW, PCPlus8D;
  logic [31:0]      RD1D, RD2D, ResultW, PCTargetW;
  logic             PCRedirectW, IllegalWrErr;
  logic [CNT_W-1:0] RetireCount;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  logic [31:0]      m_regs [15];
  logic [CNT_W-1:0] m_cnt;
  logic             m_err;

  wb_regfile_retire #(.DATA_W(32), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .PCSrcW(PCSrcW), .RegWriteW(RegWriteW),
    .MemtoRegW(MemtoRegW), .RdW(RdW), .ALUResultW(ALUResultW), .ReadDataW(ReadDataW),
    .RA1D(RA1D), .RA2D(RA2D), .PCPlus8D(PCPlus8D), .RD1D(RD1D), .RD2D(RD2D),
    .ResultW(ResultW), .PCRedirectW(PCRedirectW), .PCTargetW(PCTargetW),
    .RetireCount(RetireCount), .IllegalWrErr(IllegalWrErr)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] m_result();
    return MemtoRegW ? ReadDataW : ALUResultW;
  endfunction

  function automatic logic [31:0] m_read(input logic [3:0] a);
    if (a == 4'd15) return PCPlus8D;
`ifdef WB_BYPASS_EN
    if (RegWriteW && RdW == a) return m_result();
`endif
    return m_regs[a];
  endfunction

  // Advance one clock edge and apply the architectural rules to the model.
  task automatic tick();
    @(posedge clk);
    if (!reset) begin
      foreach (m_regs[i]) m_regs[i] = '0;
      m_cnt = '0;
      m_err = 1'b0;
    end else begin
      if (RegWriteW && RdW != 4'd15) m_regs[RdW] = m_result();
      if (RegWriteW || PCSrcW) m_cnt = m_cnt + CNT_W'(1);
      if (RegWriteW && RdW == 4'd15 && !PCSrcW) m_err = 1'b1;
    end
    #1;
  endtask

  task automatic idle();
    PCSrcW = 1'b0; RegWriteW = 1'b0; MemtoRegW = 1'b0; RdW = 4'd0;
    ALUResultW = '0; ReadDataW = '0; RA1D = 4'd0; RA2D = 4'd0; PCPlus8D = 32'h8;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle();
    tick();
    tick();
    reset = 1'b1;
    for (int i = 0; i < 15; i++) begin
      RA1D = 4'(i);
      RA2D = 4'(14 - i);
      #1;
      vectors++;
      if (RD1D !== 32'h0) begin miscompares++; $display("FAIL reset_rd1 r%0d got %h expected 0", i, RD1D); end
      vectors++;
      if (RD2D !== 32'h0) begin miscompares++; $display("FAIL reset_rd2 r%0d got %h expected 0", 14 - i, RD2D); end
    end
    vectors++;
    if (RetireCount !== '0) begin miscompares++; $display("FAIL reset_count got %0d expected 0", RetireCount); end
    vectors++;
    if (IllegalWrErr !== 1'b0) begin miscompares++; $display("FAIL reset_err got %b expected 0", IllegalWrErr); end
  endtask

  task automatic test_alu_writeback();
    idle();
    RegWriteW = 1'b1; RdW = 4'd3; ALUResultW = 32'h0000_00A5; ReadDataW = 32'h5555_5555;
    #1;
    vectors++;
    if (ResultW !== 32'h0000_00A5) begin miscompares++; $display("FAIL alu_result got %h expected 000000a5", ResultW); end
    tick();
    idle();
    RA1D = 4'd3;
    #1;
    vectors++;
    if (RD1D !== 32'h0000_00A5) begin miscompares++; $display("FAIL alu_read got %h expected 000000a5", RD1D); end
    vectors++;
    if (RetireCount !== CNT_W'(1)) begin miscompares++; $display("FAIL alu_count got %0d expected 1", RetireCount); end
  endtask

  task automatic test_load_bypass();
    logic [31:0] exp_same;
    idle();
    RegWriteW = 1'b1; MemtoRegW = 1'b1; RdW = 4'd7;
    ReadDataW = 32'hDEAD_BEEF; ALUResultW = 32'h1111_1111; RA2D = 4'd7;
`ifdef WB_BYPASS_EN
    exp_same = 32'hDEAD_BEEF;
`else
    exp_same = 32'h0;
`endif
    #1;
    vectors++;
    if (ResultW !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL load_result got %h expected deadbeef", ResultW); end
    vectors++;
    if (RD2D !== exp_same) begin miscompares++; $display("FAIL load_same_cycle got %h expected %h", RD2D, exp_same); end
    tick();
    idle();
    RA2D = 4'd7;
    #1;
    vectors++;
    if (RD2D !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL load_next_cycle got %h expected deadbeef", RD2D); end
  endtask

  task automatic test_branch();
    logic [CNT_W-1:0] cnt_before;
    cnt_before = m_cnt;
    idle();
    PCSrcW = 1'b1; RegWriteW = 1'b1; RdW = 4'd15; ALUResultW = 32'h0000_0200;
    #1;
    vectors++;
    if (PCRedirectW !== 1'b1) begin miscompares++; $display("FAIL branch_redirect got %b expected 1", PCRedirectW); end
    vectors++;
    if (PCTargetW !== 32'h0000_0200) begin miscompares++; $display("FAIL branch_target got %h expected 00000200", PCTargetW); end
    tick();
    idle();
    #1;
    vectors++;
    if (PCRedirectW !== 1'b0) begin miscompares++; $display("FAIL branch_no_hold got %b expected 0", PCRedirectW); end
    vectors++;
    if (RetireCount !== cnt_before + CNT_W'(1)) begin miscompares++; $display("FAIL branch_count got %0d expected %0d", RetireCount, cnt_before + CNT_W'(1)); end
    vectors++;
    if (IllegalWrErr !== 1'b0) begin miscompares++; $display("FAIL branch_err got %b expected 0", IllegalWrErr); end
    for (int i = 0; i < 15; i++) begin
      RA1D = 4'(i);
      #1;
      vectors++;
      if (RD1D !== m_regs[i]) begin miscompares++; $display("FAIL branch_array r%0d got %h expected %h", i, RD1D, m_regs[i]); end
    end
  endtask

  task automatic test_r15_illegal();
    idle();
    RA1D = 4'd15; PCPlus8D = 32'h0000_0108;
    #1;
    vectors++;
    if (RD1D !== 32'h0000_0108) begin miscompares++; $display("FAIL r15_read got %h expected 00000108", RD1D); end
    RegWriteW = 1'b1; RdW = 4'd15; ALUResultW = $urandom;
    tick();
    idle();
    for (int i = 0; i < 11; i++) begin
      #1;
      vectors++;
      if (IllegalWrErr !== 1'b1) begin miscompares++; $display("FAIL illegal_sticky cyc%0d got %b expected 1", i, IllegalWrErr); end
      tick();
    end
    for (int i = 0; i < 15; i++) begin
      RA2D = 4'(i);
      #1;
      vectors++;
      if (RD2D !== m_regs[i]) begin miscompares++; $display("FAIL illegal_array r%0d got %h expected %h", i, RD2D, m_regs[i]); end
    end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    vectors++;
    if (IllegalWrErr !== 1'b0) begin miscompares++; $display("FAIL illegal_cleared got %b expected 0", IllegalWrErr); end
  endtask

  task automatic test_wrap_and_reset_priority();
    idle();
    for (int i = 0; i < 16; i++) begin
      RegWriteW = 1'b1; RdW = 4'(i % 15); ALUResultW = $urandom | 32'h1;
      tick();
      if (i == 14) begin
        vectors++;
        if (RetireCount !== 4'd15) begin miscompares++; $display("FAIL wrap_top got %0d expected 15", RetireCount); end
      end
    end
    idle();
    RA1D = 4'd2;
    #1;
    vectors++;
    if (RetireCount !== 4'd0) begin miscompares++; $display("FAIL wrap_zero got %0d expected 0", RetireCount); end
    vectors++;
    if (RD1D === 32'h0) begin miscompares++; $display("FAIL wrap_r2_written got %h expected nonzero", RD1D); end
    RegWriteW = 1'b1; RdW = 4'd2; ALUResultW = 32'hCAFE_F00D;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    idle();
    RA1D = 4'd2;
    #1;
    vectors++;
    if (RD1D !== 32'h0) begin miscompares++; $display("FAIL rstprio_r2 got %h expected 0", RD1D); end
    vectors++;
    if (RetireCount !== 4'd0) begin miscompares++; $display("FAIL rstprio_count got %0d expected 0", RetireCount); end
  endtask

  task automatic test_random();
    logic [31:0] e1, e2, er;
    for (int n = 0; n < 400; n++) begin
      reset      = ($urandom_range(31) != 0);
      RegWriteW  = 1'($urandom_range(1));
      PCSrcW     = ($urandom_range(3) == 0);
      MemtoRegW  = 1'($urandom_range(1));
      RdW        = 4'($urandom_range(15));
      ALUResultW = $urandom;
      ReadDataW  = $urandom;
      PCPlus8D   = $urandom;
      RA1D       = ($urandom_range(3) == 0) ? RdW : 4'($urandom_range(15));
      RA2D       = ($urandom_range(3) == 0) ? RdW : 4'($urandom_range(15));
      #1;
      e1 = m_read(RA1D);
      e2 = m_read(RA2D);
      er = m_result();
      vectors++;
      if (RD1D !== e1) begin miscompares++; $display("FAIL rand_rd1 n%0d ra%0d got %h expected %h", n, RA1D, RD1D, e1); end
      vectors++;
      if (RD2D !== e2) begin miscompares++; $display("FAIL rand_rd2 n%0d ra%0d got %h expected %h", n, RA2D, RD2D, e2); end
      vectors++;
      if (ResultW !== er || PCTargetW !== er) begin miscompares++; $display("FAIL rand_result n%0d got %h/%h expected %h", n, ResultW, PCTargetW, er); end
      vectors++;
      if (PCRedirectW !== PCSrcW) begin miscompares++; $display("FAIL rand_redirect n%0d got %b expected %b", n, PCRedirectW, PCSrcW); end
      vectors++;
      if (RetireCount !== m_cnt) begin miscompares++; $display("FAIL rand_count n%0d got %0d expected %0d", n, RetireCount, m_cnt); end
      vectors++;
      if (IllegalWrErr !== m_err) begin miscompares++; $display("FAIL rand_err n%0d got %b expected %b", n, IllegalWrErr, m_err); end
      tick();
    end
    reset = 1'b1;
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_alu_writeback();
    test_load_bypass();
    test_branch();
    test_r15_illegal();
    test_wrap_and_reset_priority();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
